serial_sub_ctrl: RTL

SERIAL_SUB_CTRL -- requirements
Module: serial_sub_ctrl

---
 rtl/serial_sub_ctrl.sv | 108 ++++++++++
 1 files changed

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor a - b using one full-subtractor cell, LSB first.
// Latency: WIDTH+1 edges from the accepting edge to the edge that samples done=1.
// Backpressure: none; start is ignored while busy. Optional ovf port under SERIAL_SUB_OVF_EN.
module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             brw;
  logic [CNT_W-1:0] cnt;

  logic x_bit;
  logic y_bit;
  logic d_bit;
  logic b_bit;

  // Single full-subtractor cell fed from the shift register LSBs and the borrow flop
  always_comb begin
    x_bit = a_sh[0];
    y_bit = b_sh[0];
    d_bit = x_bit ^ y_bit ^ brw;
    b_bit = (~x_bit & y_bit) | (~(x_bit ^ y_bit) & brw);
  end

  // Control FSM, operand shifters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      a_sh       <= '0;
      b_sh       <= '0;
      brw        <= 1'b0;
      cnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf        <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            brw   <= 1'b0;
            cnt   <= '0;
            state <= RUN;
            busy  <= 1'b1;
            done  <= 1'b0;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        end
        RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          brw  <= b_bit;
          diff <= {d_bit, diff[WIDTH-1:1]};
          cnt  <= cnt + 1'b1;
          if (cnt == LAST_BIT) begin
            // Last cell evaluation sees the sign bits of a, b and diff
            state      <= DONE;
            busy       <= 1'b0;
            done       <= 1'b1;
            borrow_out <= b_bit;
`ifdef SERIAL_SUB_OVF_EN
            ovf        <= (x_bit ^ y_bit) & (d_bit ^ x_bit);
`endif
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
